mem_stage_unit: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage_dmem_handshake_fsm.sv | 102 ++++++++++
 rtl/mem_stage_unit.sv | 96 +++++++++
 tb/tb_mem_stage_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access stage controller.
package mem_stage_pkg;

  localparam int DATA_LEN_DEF         = 64;
  localparam int CONTROL_LINE_DEF     = 5;
  localparam int INSTRUCTION_PART_DEF = 5;
  localparam int TIMEOUT_DEF          = 255;

  // Control-bus bit positions
  localparam int CTL_MEM_READ   = 0;
  localparam int CTL_MEM_WRITE  = 1;
  localparam int CTL_REG_WRITE  = 2;
  localparam int CTL_MEM_TO_REG = 3;
  localparam int CTL_BRANCH     = 4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } hs_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data-memory port between the MEM stage and data memory.
interface mem_stage_if #(
  parameter int DATA_LEN = 64
);
  logic                dmem_req;
  logic                dmem_we;
  logic [DATA_LEN-1:0] dmem_addr;
  logic [DATA_LEN-1:0] dmem_wdata;
  logic                dmem_ack;
  logic [DATA_LEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_dmem_handshake_fsm.sv
// Data-memory handshake: issues one request per memory op, waits for ack or timeout.
//   state       | meaning
//   ST_IDLE     | no access outstanding; a memory op issues a request at the next edge
//   ST_WAIT_ACK | request held stable until ack or TIMEOUT cycles elapse
module dmem_handshake_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [DATA_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wdata,
  mem_stage_if.master         dmem,
  output logic                stall,
  output logic                pass,
  output logic                done,
  output logic                timeout,
  output logic                mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  hs_state_t     state, state_nx;
  logic [CW-1:0] cnt;
  logic          mem_op;
  logic          stall_c;

  assign mem_op = mem_read | mem_write;
  // Reset forces the stage idle, so the stall must drop with it.
  assign stall  = stall_c & ~rst;

  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    pass     = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          stall_c  = 1'b1;
          state_nx = ST_WAIT_ACK;
        end else begin
          pass = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (dmem.dmem_ack) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      mem_err         <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= mem_write;
            dmem.dmem_addr  <= addr;
            dmem.dmem_wdata <= wdata;
            cnt             <= '0;
          end
        end
        ST_WAIT_ACK: begin
          if (done || timeout) begin
            dmem.dmem_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (timeout) begin
            mem_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: drives the data-memory handshake, resolves beq against the carried
// prediction, and registers results toward write-back.
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_LEN         = DATA_LEN_DEF,
  parameter int CONTROL_LINE     = CONTROL_LINE_DEF,
  parameter int INSTRUCTION_PART = INSTRUCTION_PART_DEF,
  parameter int TIMEOUT          = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_beq_in,
  input  logic [CONTROL_LINE-1:0]     control_in,
  input  logic                        zero_in,
  input  logic [DATA_LEN-1:0]         alu_val_in,
  input  logic [DATA_LEN-1:0]         wr_addr_in,
  input  logic [INSTRUCTION_PART-1:0] instruction_part_in,
  input  logic                        predictor_in,
  mem_stage_if.master                 dmem,
  output logic                        stall,
  output logic                        ex_flush,
  output logic                        pred_upd_valid,
  output logic                        pred_upd_taken,
  output logic                        wb_reg_write,
  output logic                        wb_mem_to_reg,
  output logic [INSTRUCTION_PART-1:0] wb_rd,
  output logic [DATA_LEN-1:0]         wb_alu_val,
  output logic [DATA_LEN-1:0]         wb_mem_data,
  output logic                        mem_err
);

  logic pass, done, timeout;
  logic complete, bubble, is_load, wb_valid;

  dmem_handshake_fsm #(
    .DATA_LEN (DATA_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_hs (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (control_in[CTL_MEM_READ]),
    .mem_write (control_in[CTL_MEM_WRITE]),
    .addr      (alu_val_in),
    .wdata     (wr_addr_in),
    .dmem      (dmem),
    .stall     (stall),
    .pass      (pass),
    .done      (done),
    .timeout   (timeout),
    .mem_err   (mem_err)
  );

  // Upstream is held while stalled, so the inputs still describe the
  // instruction on its completion edge.
  assign complete = pass | done | timeout;
  assign bubble   = (control_in == '0) && !if_beq_in;
  assign is_load  = control_in[CTL_MEM_READ] & ~control_in[CTL_MEM_WRITE];
  assign wb_valid = complete & ~bubble & ~timeout & control_in[CTL_REG_WRITE];

  // Stalled edges send a bubble to write-back; pulses are rebuilt every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_flush       <= 1'b0;
      pred_upd_valid <= 1'b0;
      pred_upd_taken <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_rd          <= '0;
      wb_alu_val     <= '0;
      wb_mem_data    <= '0;
    end else begin
      ex_flush       <= 1'b0;
      pred_upd_valid <= 1'b0;
      pred_upd_taken <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_rd          <= '0;
      wb_alu_val     <= '0;
      wb_mem_data    <= '0;
      if (complete && if_beq_in) begin
        pred_upd_valid <= 1'b1;
        pred_upd_taken <= zero_in;
        ex_flush       <= zero_in ^ predictor_in;
      end
      if (wb_valid) begin
        wb_reg_write  <= 1'b1;
        wb_mem_to_reg <= control_in[CTL_MEM_TO_REG];
        wb_rd         <= instruction_part_in;
        wb_alu_val    <= alu_val_in;
        wb_mem_data   <= (done && is_load) ? dmem.dmem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed and randomized bench for mem_stage_unit against a transaction-level model.
module tb_mem_stage_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_beq_in, zero_in, predictor_in;
  logic [4:0]  control_in;
  logic [63:0] alu_val_in, wr_addr_in;
  logic [4:0]  instruction_part_in;
  logic        stall, ex_flush, pred_upd_valid, pred_upd_taken;
  logic        wb_reg_write, wb_mem_to_reg, mem_err;
  logic [4:0]  wb_rd;
  logic [63:0] wb_alu_val, wb_mem_data;

  int checks   = 0;
  int failures = 0;
  bit exp_err  = 0;

  mem_stage_if #(.DATA_LEN(64)) dmem ();

  mem_stage_unit #(
    .DATA_LEN(64), .CONTROL_LINE(5), .INSTRUCTION_PART(5), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .if_beq_in(if_beq_in), .control_in(control_in),
    .zero_in(zero_in), .alu_val_in(alu_val_in), .wr_addr_in(wr_addr_in),
    .instruction_part_in(instruction_part_in), .predictor_in(predictor_in),
    .dmem(dmem), .stall(stall), .ex_flush(ex_flush),
    .pred_upd_valid(pred_upd_valid), .pred_upd_taken(pred_upd_taken),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .wb_alu_val(wb_alu_val), .wb_mem_data(wb_mem_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, dmem.dmem_req, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_flush"}, ex_flush, 0);
    chk({tag, "_pvalid"}, pred_upd_valid, 0);
    chk({tag, "_ptaken"}, pred_upd_taken, 0);
    chk({tag, "_wbrw"}, wb_reg_write, 0);
    chk({tag, "_wbm2r"}, wb_mem_to_reg, 0);
    chk({tag, "_wbrd"}, wb_rd, 0);
    chk({tag, "_wbalu"}, wb_alu_val, 0);
    chk({tag, "_wbmem"}, wb_mem_data, 0);
    chk({tag, "_err"}, mem_err, 0);
  endtask

  // One instruction from issue to completion. ack_at is the WAIT_ACK cycle
  // (1-based) in which memory acknowledges; outside 1..TMO means never.
  task automatic exec(input logic [4:0] ctl, input logic beq, input logic zero,
                      input logic pred, input logic [63:0] alu, input logic [63:0] wd,
                      input logic [4:0] rd, input int ack_at);
    bit          mem, acked, to, ld;
    logic [63:0] rdat;
    mem   = ctl[0] | ctl[1];
    ld    = ctl[0] & ~ctl[1];
    acked = 0;
    to    = 0;
    rdat  = 0;
    control_in = ctl; if_beq_in = beq; zero_in = zero; predictor_in = pred;
    alu_val_in = alu; wr_addr_in = wd; instruction_part_in = rd;
    dmem.dmem_ack = 0;
    #1 chk("stall_issue", stall, mem);
    @(posedge clk); #1;
    if (mem) begin
      for (int w = 1; w <= TMO; w++) begin
        chk("req_held", dmem.dmem_req, 1);
        chk("addr_held", dmem.dmem_addr, alu);
        chk("wdata_held", dmem.dmem_wdata, wd);
        chk("we_held", dmem.dmem_we, ctl[1]);
        chk("wb_during_stall", wb_reg_write, 0);
        chk("flush_during_stall", ex_flush, 0);
        rdat = {$urandom, $urandom};
        dmem.dmem_rdata = rdat;
        acked = (w == ack_at);
        to    = !acked && (w == TMO);
        dmem.dmem_ack = acked;
        #1 chk("stall_wait", stall, !(acked || to));
        @(posedge clk); #1;
        dmem.dmem_ack = 0;
        if (acked || to) break;
      end
      chk("req_drop", dmem.dmem_req, 0);
      if (to) exp_err = 1;
    end
    chk("mem_err", mem_err, exp_err);
    if (ctl[2] && !to) begin
      chk("wb_reg_write", wb_reg_write, 1);
      chk("wb_mem_to_reg", wb_mem_to_reg, ctl[3]);
      chk("wb_rd", wb_rd, rd);
      chk("wb_alu_val", wb_alu_val, alu);
      chk("wb_mem_data", wb_mem_data, (mem && ld) ? rdat : 64'd0);
    end else begin
      chk("wb_reg_write_0", wb_reg_write, 0);
      chk("wb_rd_0", wb_rd, 0);
      chk("wb_alu_val_0", wb_alu_val, 0);
      chk("wb_mem_data_0", wb_mem_data, 0);
    end
    chk("pred_upd_valid", pred_upd_valid, beq);
    chk("pred_upd_taken", pred_upd_taken, beq & zero);
    chk("ex_flush", ex_flush, beq & (zero ^ pred));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; control_in = 0; if_beq_in = 0; zero_in = 0; predictor_in = 0;
    alu_val_in = 0; wr_addr_in = 0; instruction_part_in = 0;
    dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
    #1 chk_all_zero("reset");
    @(posedge clk); #1 rst = 0;

    // Reset in the middle of an outstanding load
    control_in = 5'b01101; alu_val_in = 64'h200; instruction_part_in = 5'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_req", dmem.dmem_req, 1);
    chk("pre_reset_stall", stall, 1);
    rst = 1;
    #1 chk_all_zero("mid_reset");
    @(posedge clk); #1;
    control_in = 0; rst = 0;
    @(posedge clk); #1;
    chk("post_reset_req", dmem.dmem_req, 0);

    // ALU op right after reset completes in one cycle with no stall
    exec(5'b00100, 0, 0, 0, 64'h1234, 64'h0, 5'd5, 0);
    // Load, ack in third WAIT_ACK cycle
    exec(5'b01101, 0, 0, 0, 64'h100, 64'h0, 5'd7, 3);
    if (wb_mem_data !== 64'hDEAD) begin
      // rdata was random; repeat with the fixed value for a visible check
    end
    control_in = 5'b01101; alu_val_in = 64'h100; instruction_part_in = 5'd7;
    #1 chk("ld_stall_c0", stall, 1);
    @(posedge clk); #1;
    for (int w = 1; w <= 3; w++) begin
      chk("ld_req", dmem.dmem_req, 1);
      chk("ld_addr", dmem.dmem_addr, 64'h100);
      dmem.dmem_rdata = 64'hDEAD;
      dmem.dmem_ack   = (w == 3);
      #1 chk("ld_stall", stall, (w != 3));
      @(posedge clk); #1;
      dmem.dmem_ack = 0;
    end
    chk("ld_wb_mem_data", wb_mem_data, 64'hDEAD);
    chk("ld_wb_rd", wb_rd, 5'd7);
    chk("ld_req_low", dmem.dmem_req, 0);

    // Store with no ack: times out
    exec(5'b00010, 0, 0, 0, 64'h300, 64'hCAFE, 5'd0, 0);
    exec(5'b00000, 0, 0, 0, 64'h0, 64'h0, 5'd0, 0);
    chk("err_sticky", mem_err, 1);

    // Branches: mispredict then correct prediction
    exec(5'b10000, 1, 1, 0, 64'h0, 64'h0, 5'd0, 0);
    exec(5'b10000, 1, 0, 0, 64'h0, 64'h0, 5'd0, 0);

    // Bubbles then back-to-back mispredicted beqs
    for (int i = 0; i < 3; i++) exec(5'b00000, 0, 0, 0, 64'h0, 64'h0, 5'd0, 0);
    exec(5'b10000, 1, 1, 0, 64'h0, 64'h0, 5'd0, 0);
    exec(5'b10000, 1, 0, 1, 64'h0, 64'h0, 5'd0, 0);
    exec(5'b00000, 0, 0, 0, 64'h0, 64'h0, 5'd0, 0);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      exec(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, {$urandom, $urandom},
           5'($urandom_range(0, 31)), int'($urandom_range(1, TMO + 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
